simd_shift_issue: RTL
=====================

Name: simd_shift_issue

Overview:
- Issue/operand stage directly upstream of the shift64 SIMD shifter.
- Accepts shift micro-ops from decode via a valid/ready handshake and decodes the opcode into shift64 control fields (mode_unified, dir/arith per lane, packed 12-bit shift_amt).
- Registers the operand bus and controls with a 2-entry skid buffer, so shift64 sees stable, registered inputs and backpressure never drops a beat.

Parameters:
- XLEN, 64, operand width; the split lane width is XLEN/2.
- RDW, 5, destination register tag width.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous pipeline flush.
- in_valid  in  1  upstream micro-op valid.
- in_ready  out  1  stage can accept this cycle.
- in_op  in  4  shift opcode (package encoding).
- in_rs1  in  XLEN  operand to shift.
- in_rs2  in  XLEN  amounts / lane controls.
- in_rd  in  RDW  destination tag.
- out_valid  out  1  registered micro-op valid toward shift64.
- out_ready  in  1  downstream accepts.
- mode_unified, uni_dir, uni_arith  out  1 each  shift64 controls.
- hi_dir, hi_arith, lo_dir, lo_arith  out  1 each  split-lane controls.
- shift_amt  out  12  {hi_amt[5:0], lo_amt[5:0]} in split mode; {6'b0, amt[5:0]} in unified mode.
- in_bus  out  XLEN  registered in_rs1.
- out_rd  out  RDW  registered tag.
- out_illegal  out  1  opcode was not recognised.

Behaviour:
- Reset: while rst=1, all outputs are 0 (in_ready=0). Skid and output entries are cleared. in_ready=1 in the first cycle after rst deasserts.
- Accept: a beat is accepted when in_valid && in_ready. Latency is 1 cycle: an accepted beat appears on the outputs the next cycle if the output register is empty or draining.
- Output register hold: out_valid stays high and all outputs stay stable until out_ready=1. Outputs must not change while out_valid && !out_ready.
- Skid entry: if a beat is accepted while the output register is held, it goes to the skid entry. in_ready = !skid_full, registered. On drain, the skid entry moves to the output register; FIFO order is strict.
- Simultaneous drain and accept with skid full: not possible, since in_ready=0. With skid empty, drain and accept in the same cycle loads the output register directly.
- flush: takes priority over accept and drain. The next cycle has out_valid=0, skid empty and in_ready=1. A beat presented in the flush cycle is discarded.
- rst takes priority over flush. Reset mid-transfer drops all held beats.
- Decode:
  - SLL64/SRL64/SRA64: mode_unified=1; uni_dir = 0/1/1; uni_arith = 0/0/1; shift_amt = {6'b0, rs2[5:0]}, masked to 6 bits.
  - SLL32X2/SRL32X2/SRA32X2: mode_unified=0; both lanes get the same dir/arith as the 64-bit op; lo_amt = {1'b0, rs2[4:0]}, hi_amt = {1'b0, rs2[36:32]}; amounts are masked to 5 bits.
  - SHMIX32: mode_unified=0; hi_dir=rs2[63], hi_arith=rs2[62]&rs2[63]; lo_dir=rs2[31], lo_arith=rs2[30]&rs2[31]; amounts as in the 32X2 ops.
- Arith is never asserted with dir=0. Unused-mode controls are driven 0.
- Illegal opcode: out_illegal=1 with controls forced to pass-through (mode_unified=1, uni_dir=0, shift_amt=0). The beat still flows and in_bus = rs1.
- All decode is combinational before the register; no output is combinational from any input.

Decomposition:
- Package simd_shift_pkg:
  - opcode localparams: SLL64=0, SRL64=1, SRA64=2, SLL32X2=4, SRL32X2=5, SRA32X2=6, SHMIX32=8.
  - SHAMT_W=6 and a packed control-bundle struct shared with shift64.
- One sub-module, simd_shift_decode: purely combinational op -> control bundle + illegal flag. The top level holds the skid buffer.

Test Plan:
- SRA32X2, rs1=64'hFEDCBA9876543210, rs2=64'h00000002_00000003 -> next cycle: mode_unified=0, hi_dir=lo_dir=1, hi_arith=lo_arith=1, shift_amt=12'h083, in_bus=rs1.
- SLL64 with rs2=40, then rs2=104 -> mode_unified=1, uni_dir=0, uni_arith=0, shift_amt=12'h028 both times (mask check).
- Backpressure: out_ready=0, send beats A,B,C back-to-back -> A held stable, B in skid, in_ready=0 from the cycle after B. C stays pending. Raise out_ready -> A, B, C emerge in order with no loss or duplication.
- SHMIX32, rs2=64'hC0000005_00000007 -> hi_dir=1, hi_arith=1, lo_dir=0, lo_arith=0, shift_amt=12'h147.
- in_op=4'hF -> out_illegal=1, mode_unified=1, shift_amt=0, in_bus=rs1.
- flush with skid full, then rst asserted mid-stream -> after flush: out_valid=0, in_ready=1. While rst=1: all outputs 0. First cycle after rst: in_ready=1.

Source files
------------

// File: rtl/simd_shift_pkg.sv
// Shared definitions for the shift issue stage and the shift64 datapath:
// opcode encoding, amount width and the control bundle handed to shift64.
package simd_shift_pkg;

    localparam logic [3:0] SLL64   = 4'd0;
    localparam logic [3:0] SRL64   = 4'd1;
    localparam logic [3:0] SRA64   = 4'd2;
    localparam logic [3:0] SLL32X2 = 4'd4;
    localparam logic [3:0] SRL32X2 = 4'd5;
    localparam logic [3:0] SRA32X2 = 4'd6;
    localparam logic [3:0] SHMIX32 = 4'd8;

    localparam int SHAMT_W = 6;

    typedef struct packed {
        logic                   mode_unified;
        logic                   uni_dir;
        logic                   uni_arith;
        logic                   hi_dir;
        logic                   hi_arith;
        logic                   lo_dir;
        logic                   lo_arith;
        logic [2*SHAMT_W-1:0]   shift_amt;
    } shift_ctrl_t;

    // Lane amounts are 5 bits wide; the top bit of the 6-bit field is always 0.
    function automatic logic [SHAMT_W-1:0] lane_amt(input logic [4:0] amt);
        return {1'b0, amt};
    endfunction

endpackage

// File: rtl/simd_shift_decode.sv
// Combinational opcode decode: shift micro-op -> shift64 control bundle
// plus an illegal-opcode flag.
module simd_shift_decode
    import simd_shift_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [3:0]      op_i,
    input  logic [XLEN-1:0] rs2_i,
    output shift_ctrl_t     ctrl_o,
    output logic            illegal_o
);

    localparam int HALF = XLEN / 2;

    logic [SHAMT_W-1:0] lo_amt_s;
    logic [SHAMT_W-1:0] hi_amt_s;
    logic               op_dir_s;
    logic               op_arith_s;
    logic               rs2_unused_s;

    assign lo_amt_s     = lane_amt(rs2_i[4:0]);
    assign hi_amt_s     = lane_amt(rs2_i[HALF+4:HALF]);
    assign rs2_unused_s = ^{rs2_i[XLEN-3:HALF+5], rs2_i[HALF-3:SHAMT_W]};

    // Low two opcode bits select left / logical right / arithmetic right.
    assign op_dir_s   = (op_i[1:0] != 2'd0);
    assign op_arith_s = (op_i[1:0] == 2'd2);

    // Field decode; every mode drives its unused controls to 0.
    always_comb begin
        ctrl_o    = '0;
        illegal_o = 1'b0;
        case (op_i)
            SLL64, SRL64, SRA64: begin
                ctrl_o.mode_unified = 1'b1;
                ctrl_o.uni_dir      = op_dir_s;
                ctrl_o.uni_arith    = op_arith_s;
                ctrl_o.shift_amt    = {{SHAMT_W{1'b0}}, rs2_i[SHAMT_W-1:0]};
            end
            SLL32X2, SRL32X2, SRA32X2: begin
                ctrl_o.mode_unified = 1'b0;
                ctrl_o.hi_dir       = op_dir_s;
                ctrl_o.hi_arith     = op_arith_s;
                ctrl_o.lo_dir       = op_dir_s;
                ctrl_o.lo_arith     = op_arith_s;
                ctrl_o.shift_amt    = {hi_amt_s, lo_amt_s};
            end
            SHMIX32: begin
                ctrl_o.mode_unified = 1'b0;
                ctrl_o.hi_dir       = rs2_i[XLEN-1];
                ctrl_o.hi_arith     = rs2_i[XLEN-2] & rs2_i[XLEN-1];
                ctrl_o.lo_dir       = rs2_i[HALF-1];
                ctrl_o.lo_arith     = rs2_i[HALF-2] & rs2_i[HALF-1];
                ctrl_o.shift_amt    = {hi_amt_s, lo_amt_s};
            end
            default: begin
                ctrl_o.mode_unified = 1'b1;
                illegal_o           = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/simd_shift_issue.sv
// Issue/operand stage in front of shift64: decodes shift micro-ops and holds
// them in an output register backed by a one-entry skid register.
module simd_shift_issue
    import simd_shift_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int RDW  = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [3:0]           in_op,
    input  logic [XLEN-1:0]      in_rs1,
    input  logic [XLEN-1:0]      in_rs2,
    input  logic [RDW-1:0]       in_rd,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 mode_unified,
    output logic                 uni_dir,
    output logic                 uni_arith,
    output logic                 hi_dir,
    output logic                 hi_arith,
    output logic                 lo_dir,
    output logic                 lo_arith,
    output logic [2*SHAMT_W-1:0] shift_amt,
    output logic [XLEN-1:0]      in_bus,
    output logic [RDW-1:0]       out_rd,
    output logic                 out_illegal
);

    typedef struct packed {
        shift_ctrl_t     ctrl;
        logic            illegal;
        logic [XLEN-1:0] bus;
        logic [RDW-1:0]  rd;
    } beat_t;

    shift_ctrl_t dec_ctrl_s;
    logic        dec_illegal_s;
    beat_t       in_beat_s;
    logic        accept_s;
    logic        out_free_s;

    logic        out_valid_q, out_valid_d;
    beat_t       out_beat_q,  out_beat_d;
    logic        skid_valid_q, skid_valid_d;
    beat_t       skid_beat_q,  skid_beat_d;
    logic        in_ready_q;

    simd_shift_decode #(
        .XLEN (XLEN)
    ) u_decode (
        .op_i      (in_op),
        .rs2_i     (in_rs2),
        .ctrl_o    (dec_ctrl_s),
        .illegal_o (dec_illegal_s)
    );

    assign in_beat_s.ctrl    = dec_ctrl_s;
    assign in_beat_s.illegal = dec_illegal_s;
    assign in_beat_s.bus     = in_rs1;
    assign in_beat_s.rd      = in_rd;

    assign accept_s   = in_valid && in_ready_q;
    assign out_free_s = !out_valid_q || out_ready;

    // Next state of the output/skid pair; in_ready is low whenever the skid
    // entry is occupied, so an accept never coincides with a full skid.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_beat_d   = out_beat_q;
        skid_valid_d = skid_valid_q;
        skid_beat_d  = skid_beat_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (out_free_s) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_beat_d   = skid_beat_q;
                skid_valid_d = 1'b0;
            end else if (accept_s) begin
                out_valid_d  = 1'b1;
                out_beat_d   = in_beat_s;
            end else begin
                out_valid_d  = 1'b0;
            end
        end else if (accept_s) begin
            skid_valid_d = 1'b1;
            skid_beat_d  = in_beat_s;
        end else begin
            skid_valid_d = skid_valid_q;
        end
    end

    // State registers; reset clears everything including in_ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_beat_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_beat_q  <= '0;
            in_ready_q   <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_beat_q   <= out_beat_d;
            skid_valid_q <= skid_valid_d;
            skid_beat_q  <= skid_beat_d;
            in_ready_q   <= !skid_valid_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign out_valid    = out_valid_q;
    assign mode_unified = out_beat_q.ctrl.mode_unified;
    assign uni_dir      = out_beat_q.ctrl.uni_dir;
    assign uni_arith    = out_beat_q.ctrl.uni_arith;
    assign hi_dir       = out_beat_q.ctrl.hi_dir;
    assign hi_arith     = out_beat_q.ctrl.hi_arith;
    assign lo_dir       = out_beat_q.ctrl.lo_dir;
    assign lo_arith     = out_beat_q.ctrl.lo_arith;
    assign shift_amt    = out_beat_q.ctrl.shift_amt;
    assign in_bus       = out_beat_q.bus;
    assign out_rd       = out_beat_q.rd;
    assign out_illegal  = out_beat_q.illegal;

endmodule
